// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: write-back select and load funct3 encodings.
package rv32i_types;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;
  localparam int unsigned RD_W  = 5;

  typedef enum logic [1:0] {
    ALU  = 2'd0,
    LOAD = 2'd1,
    PC4  = 2'd2,
    AUX  = 2'd3
  } wb_sel_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM->WB entry, pipeline control and register-file write port bundle.
interface writeback_stage_if;
  import rv32i_types::*;

  logic                  stall_i;
  logic                  flush_i;
  logic                  mem_valid_i;
  logic                  mem_regwrite_i;
  logic [RD_W-1:0]       mem_rd_i;
  wb_sel_t               mem_wb_sel_i;
  logic [2:0]            mem_funct3_i;
  logic [XLEN-1:0]       mem_alu_i;
  logic [XLEN-1:0]       mem_pc_i;
  logic [XLEN-1:0]       mem_aux_i;
  logic [XLEN-1:0]       mem_rdata_i;
  logic                  rf_load_o;
  logic [RD_W-1:0]       rf_dest_o;
  logic [XLEN-1:0]       rf_in_o;
  logic                  exc_o;
  logic                  exc_cause_o;
  logic [CNT_W-1:0]      retire_cnt_o;

  modport master (
    output stall_i, flush_i, mem_valid_i, mem_regwrite_i, mem_rd_i, mem_wb_sel_i,
           mem_funct3_i, mem_alu_i, mem_pc_i, mem_aux_i, mem_rdata_i,
    input  rf_load_o, rf_dest_o, rf_in_o, exc_o, exc_cause_o, retire_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, mem_valid_i, mem_regwrite_i, mem_rd_i, mem_wb_sel_i,
           mem_funct3_i, mem_alu_i, mem_pc_i, mem_aux_i, mem_rdata_i,
    output rf_load_o, rf_dest_o, rf_in_o, exc_o, exc_cause_o, retire_cnt_o
  );
endinterface

// File: rtl/load_align.sv
// Combinational load data alignment/extension with misalign and illegal-funct3 flags.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o,
  output logic            illegal_o
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rdata_i[{off_i, 3'b000} +: 8];
    half_v     = off_i[1] ? rdata_i[XLEN-1:16] : rdata_i[15:0];
    data_o     = '0;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      LB:      data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      LBU:     data_o = {{(XLEN-8){1'b0}}, byte_v};
      LH: begin
        data_o     = {{(XLEN-16){half_v[15]}}, half_v};
        misalign_o = off_i[0];
      end
      LHU: begin
        data_o     = {{(XLEN-16){1'b0}}, half_v};
        misalign_o = off_i[0];
      end
      LW: begin
        data_o     = rdata_i;
        misalign_o = (off_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
    // Faulting loads never leak partial memory data into the register file.
    if (misalign_o || illegal_o) data_o = '0;
  end
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, write-back select mux and retired-instruction counter.
module writeback_stage
  import rv32i_types::*;
(
  input  logic               clk,
  input  logic               rst,
  writeback_stage_if.slave   bus
);
  logic [XLEN-1:0]  ld_data;
  logic             ld_misalign;
  logic             ld_illegal;
  logic             mem_exc;
  logic             mem_cause;
  logic [XLEN-1:0]  mem_data;

  logic             rf_load_q, rf_load_d;
  logic [RD_W-1:0]  rf_dest_q, rf_dest_d;
  logic [XLEN-1:0]  rf_in_q, rf_in_d;
  logic             exc_q, exc_d;
  logic             cause_q, cause_d;
  logic             retire_ok_q, retire_ok_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  load_align u_load_align (
    .funct3_i   (bus.mem_funct3_i),
    .off_i      (bus.mem_alu_i[1:0]),
    .rdata_i    (bus.mem_rdata_i),
    .data_o     (ld_data),
    .misalign_o (ld_misalign),
    .illegal_o  (ld_illegal)
  );

  always_comb begin
    mem_exc   = (bus.mem_wb_sel_i == LOAD) && (ld_misalign || ld_illegal);
    mem_cause = (bus.mem_wb_sel_i == LOAD) && ld_illegal;
    case (bus.mem_wb_sel_i)
      ALU:     mem_data = bus.mem_alu_i;
      LOAD:    mem_data = ld_data;
      PC4:     mem_data = bus.mem_pc_i + XLEN'(4);
      default: mem_data = bus.mem_aux_i;
    endcase

    rf_load_d    = rf_load_q;
    rf_dest_d    = rf_dest_q;
    rf_in_d      = rf_in_q;
    exc_d        = exc_q;
    cause_d      = cause_q;
    retire_ok_d  = retire_ok_q;
    retire_cnt_d = retire_cnt_q;

    // An entry retires on the cycle it leaves WB, i.e. when not held by a stall.
    if (retire_ok_q && !bus.stall_i) retire_cnt_d = retire_cnt_q + CNT_W'(1);

    if (!bus.stall_i) begin
      if (bus.flush_i) begin
        rf_load_d   = 1'b0;
        exc_d       = 1'b0;
        retire_ok_d = 1'b0;
      end else begin
        rf_load_d   = bus.mem_valid_i && bus.mem_regwrite_i && !mem_exc &&
                      (bus.mem_rd_i != '0);
        rf_dest_d   = bus.mem_rd_i;
        rf_in_d     = mem_data;
        exc_d       = bus.mem_valid_i && mem_exc;
        cause_d     = mem_cause;
        retire_ok_d = bus.mem_valid_i && !mem_exc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_load_q    <= 1'b0;
      rf_dest_q    <= '0;
      rf_in_q      <= '0;
      exc_q        <= 1'b0;
      cause_q      <= 1'b0;
      retire_ok_q  <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      rf_load_q    <= rf_load_d;
      rf_dest_q    <= rf_dest_d;
      rf_in_q      <= rf_in_d;
      exc_q        <= exc_d;
      cause_q      <= cause_d;
      retire_ok_q  <= retire_ok_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.rf_load_o    = rf_load_q;
  assign bus.rf_dest_o    = rf_dest_q;
  assign bus.rf_in_o      = rf_in_q;
  assign bus.exc_o        = exc_q;
  assign bus.exc_cause_o  = cause_q;
  assign bus.retire_cnt_o = retire_cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus random checks of writeback_stage against a behavioural WB model.
module tb_writeback_stage;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Model of the WB entry as architectural fields.
  bit              m_valid, m_regwrite, m_exc, m_cause;
  bit [4:0]        m_rd;
  bit [31:0]       m_data;
  longint unsigned m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic bit [31:0] model_load(input bit [2:0] f3, input int off,
                                           input bit [31:0] rdata,
                                           output bit mis, output bit ill);
    int unsigned b, h;
    bit [31:0] v;
    b   = (rdata >> (8 * off)) % 256;
    h   = (rdata >> (16 * (off / 2))) % 65536;
    mis = 0;
    ill = 0;
    v   = 0;
    case (f3)
      3'd0: v = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: v = b;
      3'd1: begin v = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (off % 2) != 0; end
      3'd5: begin v = h; mis = (off % 2) != 0; end
      3'd2: begin v = rdata; mis = off != 0; end
      default: ill = 1;
    endcase
    if (mis || ill) v = 0;
    return v;
  endfunction

  task automatic model_edge();
    bit mis, ill, exc;
    bit [31:0] d;
    if (rst) begin
      m_valid = 0; m_regwrite = 0; m_exc = 0; m_cause = 0; m_rd = 0; m_data = 0; m_cnt = 0;
      return;
    end
    if (m_valid && !m_exc && !bus.stall_i) m_cnt++;
    if (bus.stall_i) return;
    if (bus.flush_i) begin
      m_valid = 0;
      return;
    end
    d = model_load(bus.mem_funct3_i, int'(bus.mem_alu_i % 4), bus.mem_rdata_i, mis, ill);
    exc = 0;
    case (bus.mem_wb_sel_i)
      ALU:     d = bus.mem_alu_i;
      PC4:     d = bus.mem_pc_i + 32'd4;
      AUX:     d = bus.mem_aux_i;
      default: exc = mis || ill;
    endcase
    m_valid    = bus.mem_valid_i;
    m_regwrite = bus.mem_regwrite_i;
    m_rd       = bus.mem_rd_i;
    m_data     = d;
    m_exc      = exc;
    m_cause    = (bus.mem_wb_sel_i == LOAD) && ill;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rf_load"}, 64'(bus.rf_load_o),
          64'(m_valid && m_regwrite && !m_exc && (m_rd != 0)));
    check({tag, ".rf_dest"}, 64'(bus.rf_dest_o), 64'(m_rd));
    check({tag, ".rf_in"},   64'(bus.rf_in_o),   64'(m_data));
    check({tag, ".exc"},     64'(bus.exc_o),     64'(m_valid && m_exc));
    check({tag, ".cause"},   64'(bus.exc_cause_o), 64'(m_cause));
    check({tag, ".retire"},  bus.retire_cnt_o,   m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input bit v, input bit rw, input bit [4:0] rd, input wb_sel_t sel,
                       input bit [2:0] f3, input bit [31:0] alu, input bit [31:0] pc,
                       input bit [31:0] aux, input bit [31:0] rdata);
    bus.mem_valid_i = v;    bus.mem_regwrite_i = rw; bus.mem_rd_i  = rd;
    bus.mem_wb_sel_i = sel; bus.mem_funct3_i = f3;   bus.mem_alu_i = alu;
    bus.mem_pc_i = pc;      bus.mem_aux_i = aux;     bus.mem_rdata_i = rdata;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, ALU, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    idle();
    step("reset0");
    step("reset1");
    check("reset.rf_load", 64'(bus.rf_load_o), 64'd0);
    check("reset.retire",  bus.retire_cnt_o, 64'd0);
    rst = 1'b0;

    // ALU write
    drive(1, 1, 5'd5, ALU, 3'd0, 32'h1234_5678, 32'h100, 32'h0, 32'h0);
    step("alu");
    check("alu.rf_in", 64'(bus.rf_in_o), 64'h1234_5678);
    check("alu.dest",  64'(bus.rf_dest_o), 64'd5);
    idle();
    step("alu_ret");
    check("alu.retire", bus.retire_cnt_o, 64'd1);

    // LB / LBU at offset 3
    drive(1, 1, 5'd7, LOAD, 3'b000, 32'h0000_1003, 32'h104, 32'h0, 32'h80AA_BBCC);
    step("lb");
    check("lb.rf_in", 64'(bus.rf_in_o), 64'hFFFF_FF80);
    drive(1, 1, 5'd7, LOAD, 3'b100, 32'h0000_1003, 32'h108, 32'h0, 32'h80AA_BBCC);
    step("lbu");
    check("lbu.rf_in", 64'(bus.rf_in_o), 64'h0000_0080);

    // Misaligned LH and illegal funct3
    drive(1, 1, 5'd8, LOAD, 3'b001, 32'h0000_2001, 32'h10C, 32'h0, 32'hDEAD_BEEF);
    step("lh_mis");
    check("lh_mis.exc",   64'(bus.exc_o), 64'd1);
    check("lh_mis.cause", 64'(bus.exc_cause_o), 64'd0);
    check("lh_mis.load",  64'(bus.rf_load_o), 64'd0);
    drive(1, 1, 5'd8, LOAD, 3'b011, 32'h0000_2000, 32'h110, 32'h0, 32'hDEAD_BEEF);
    step("ill");
    check("ill.cause", 64'(bus.exc_cause_o), 64'd1);

    // rd = 0
    drive(1, 1, 5'd0, AUX, 3'd0, 32'h0, 32'h114, 32'hCAFE_0000, 32'h0);
    step("rd0");
    check("rd0.load", 64'(bus.rf_load_o), 64'd0);
    idle();
    step("rd0_ret");
    check("rd0.retire", bus.retire_cnt_o, 64'd4);

    // Stall with flush asserted: held, then single retire on release
    drive(1, 1, 5'd9, ALU, 3'd0, 32'h5555_AAAA, 32'h118, 32'h0, 32'h0);
    step("stall_cap");
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    drive(1, 1, 5'd10, AUX, 3'd0, 32'h0, 32'h11C, 32'h7777_7777, 32'h0);
    for (int i = 0; i < 3; i++) step("stall_hold");
    check("stall.rf_in",  64'(bus.rf_in_o), 64'h5555_AAAA);
    check("stall.retire", bus.retire_cnt_o, 64'd4);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    idle();
    step("stall_rel");
    check("stall.release_retire", bus.retire_cnt_o, 64'd5);

    // PC4 wrap, then reset during stall
    drive(1, 1, 5'd1, PC4, 3'd0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    step("pc4");
    check("pc4.rf_in", 64'(bus.rf_in_o), 64'h0);
    check("pc4.load",  64'(bus.rf_load_o), 64'd1);
    bus.stall_i = 1'b1;
    step("pre_rst_stall");
    rst = 1'b1;
    step("rst_stall");
    check("rst_stall.retire", bus.retire_cnt_o, 64'd0);
    check("rst_stall.load",   64'(bus.rf_load_o), 64'd0);
    rst = 1'b0;
    bus.stall_i = 1'b0;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(63) == 0);
      bus.stall_i = ($urandom_range(4) == 0);
      bus.flush_i = ($urandom_range(7) == 0);
      drive(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 5'($urandom_range(31)),
            wb_sel_t'($urandom_range(3)), 3'($urandom_range(7)), $urandom, $urandom,
            $urandom, $urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
